// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the FSM encoding, acknowledge bytes and baud-select codes.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] ACK_CLEAN  = 8'h43;
  localparam logic [7:0] ACK_FINISH = 8'h4B;

  localparam logic [1:0] BAUD_SEL_0   = 2'b00;
  localparam logic [1:0] BAUD_SEL_1   = 2'b01;
  localparam logic [1:0] BAUD_SEL_2   = 2'b10;
  localparam logic [1:0] BAUD_SEL_BAD = 2'b11;

  function automatic logic baud_valid(input logic [1:0] sel);
    return (sel == BAUD_SEL_0) || (sel == BAUD_SEL_1) || (sel == BAUD_SEL_2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous push, pop and flush; flush beats both.
// Full/empty are registered from the post-update occupancy.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Push is judged against the registered full flag, so a same-cycle pop never makes room.
  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/tx_scheduler.sv
// Feeds a UART transmitter from a byte FIFO plus clean/finish acknowledge bytes,
// retrying a byte when the transmitter never reports busy.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iWRen,
  input  logic [7:0] iData,
  input  logic [1:0] irate_control,
  input  logic       iCLEAN,
  input  logic       iFINISH,
  input  logic       iTX_BUSY,
  output logic       oTX_START,
  output logic [7:0] oTX_DATA,
  output logic [1:0] oBAUD_SEL,
  output logic       oFULL,
  output logic       oEMPTY,
  output logic       oDROP,
  output state_t     oDBG_STATE
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, finish_q;
  logic          clean_pend_q, clean_pend_d;
  logic          finish_pend_q, finish_pend_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [1:0]    baud_q, baud_d;
  logic          drop_q, drop_d;
  logic          clean_edge, finish_edge;
  logic          fifo_pop, fifo_full, fifo_empty, fifo_avail;
  logic [7:0]    fifo_data;
  logic          any_src;

  assign clean_edge  = iCLEAN && !clean_q;
  assign finish_edge = iFINISH && !finish_q;
  // A flush this cycle invalidates the head, so it must not be popped alongside it.
  assign fifo_avail  = !fifo_empty && !clean_edge;
  assign any_src     = clean_pend_q || finish_pend_q || fifo_avail;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (iWRen),
    .pop_i   (fifo_pop),
    .flush_i (clean_edge),
    .data_i  (iData),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE:      if (any_src) state_d = ST_START;
      ST_START:     state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (iTX_BUSY)                              state_d = ST_WAIT_DONE;
        else if (cnt_q == CW'(BUSY_TIMEOUT - 1))   state_d = ST_START;
        else                                       cnt_d   = cnt_q + CW'(1);
      end
      ST_WAIT_DONE: if (!iTX_BUSY) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oTX_START     = (state_q == ST_START);
    tx_data_d     = tx_data_q;
    baud_d        = baud_q;
    fifo_pop      = 1'b0;
    clean_pend_d  = clean_pend_q || clean_edge;
    finish_pend_d = finish_pend_q || finish_edge;
    drop_d        = iWRen && fifo_full && !clean_edge;
    if (state_q == ST_IDLE) begin
      if (clean_pend_q) begin
        tx_data_d    = ACK_CLEAN;
        clean_pend_d = clean_edge;
      end else if (finish_pend_q) begin
        tx_data_d     = ACK_FINISH;
        finish_pend_d = finish_edge;
      end else if (fifo_avail) begin
        tx_data_d = fifo_data;
        fifo_pop  = 1'b1;
      end else if (baud_valid(irate_control)) begin
        baud_d = irate_control;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clean_q       <= 1'b0;
      finish_q      <= 1'b0;
      clean_pend_q  <= 1'b0;
      finish_pend_q <= 1'b0;
      tx_data_q     <= 8'h00;
      baud_q        <= BAUD_SEL_0;
      drop_q        <= 1'b0;
    end else begin
      clean_q       <= iCLEAN;
      finish_q      <= iFINISH;
      clean_pend_q  <= clean_pend_d;
      finish_pend_q <= finish_pend_d;
      tx_data_q     <= tx_data_d;
      baud_q        <= baud_d;
      drop_q        <= drop_d;
    end
  end

  assign oTX_DATA   = tx_data_q;
  assign oBAUD_SEL  = baud_q;
  assign oFULL      = fifo_full;
  assign oEMPTY     = fifo_empty;
  assign oDROP      = drop_q;
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: a simple transmitter model answers start pulses
// with a busy window; every started byte is logged for ordering checks.
module tb_tx_scheduler;
  import tx_sched_pkg::*;

  localparam int DEPTH = 8;
  localparam int BT    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       iWRen;
  logic [7:0] iData;
  logic [1:0] irate_control;
  logic       iCLEAN, iFINISH;
  logic       iTX_BUSY;
  logic       oTX_START, oFULL, oEMPTY, oDROP;
  logic [7:0] oTX_DATA;
  logic [1:0] oBAUD_SEL;
  state_t     oDBG_STATE;

  logic       force_busy, model_en;
  int         busy_len, busy_cnt;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0, failures = 0;

  tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .iWRen(iWRen), .iData(iData),
    .irate_control(irate_control), .iCLEAN(iCLEAN), .iFINISH(iFINISH),
    .iTX_BUSY(iTX_BUSY), .oTX_START(oTX_START), .oTX_DATA(oTX_DATA),
    .oBAUD_SEL(oBAUD_SEL), .oFULL(oFULL), .oEMPTY(oEMPTY), .oDROP(oDROP),
    .oDBG_STATE(oDBG_STATE)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles starting the cycle after a start pulse.
  always @(posedge clk) begin
    if (reset || !model_en)             busy_cnt <= 0;
    else if (oTX_START && busy_cnt == 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)             busy_cnt <= busy_cnt - 1;
  end
  assign iTX_BUSY = force_busy | (busy_cnt != 0);

  always @(negedge clk) if (oTX_START) sent_q.push_back(oTX_DATA);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t target, input int maxc, output bit ok);
    int n = 0;
    while (oDBG_STATE != target && n < maxc) begin
      tick();
      n++;
    end
    ok = (oDBG_STATE == target);
  endtask

  task automatic write_byte(input logic [7:0] d);
    iWRen = 1'b1;
    iData = d;
    tick();
    iWRen = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (oTX_START !== 1'b0) begin failures++; $display("FAIL reset_start: got %0b expected 0", oTX_START); end
    checks++; if (oTX_DATA !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 00", oTX_DATA); end
    checks++; if (oBAUD_SEL !== 2'b00) begin failures++; $display("FAIL reset_baud: got %0b expected 00", oBAUD_SEL); end
    checks++; if (oFULL !== 1'b0) begin failures++; $display("FAIL reset_full: got %0b expected 0", oFULL); end
    checks++; if (oEMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty: got %0b expected 1", oEMPTY); end
    checks++; if (oDROP !== 1'b0) begin failures++; $display("FAIL reset_drop: got %0b expected 0", oDROP); end
    checks++; if (oDBG_STATE !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", oDBG_STATE, ST_IDLE); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    model_en = 1'b1;
    busy_len = 10;
    sent_q.delete();
    iWRen = 1'b1;
    iData = 8'h41;
    tick();
    iWRen = 1'b0;
    checks++; if (oTX_START !== 1'b0) begin failures++; $display("FAIL single_n1_start: got %0b expected 0", oTX_START); end
    checks++; if (oEMPTY !== 1'b0) begin failures++; $display("FAIL single_n1_empty: got %0b expected 0", oEMPTY); end
    tick();
    checks++; if (oTX_START !== 1'b1) begin failures++; $display("FAIL single_latency: got %0b expected 1", oTX_START); end
    checks++; if (oTX_DATA !== 8'h41) begin failures++; $display("FAIL single_data: got %0h expected 41", oTX_DATA); end
    n = 0;
    do begin
      tick();
      n++;
    end while (oDBG_STATE != ST_IDLE && n < 40);
    // start at S, busy S+1..S+10, WAIT_DONE exits at S+11 -> IDLE at S+12
    checks++; if (n !== 12) begin failures++; $display("FAIL single_idle_cycles: got %0d expected 12", n); end
    checks++; if (sent_q.size() !== 1) begin failures++; $display("FAIL single_count: got %0d expected 1", sent_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    model_en   = 1'b0;
    force_busy = 1'b1;
    write_byte(8'hA0);
    wait_state(ST_WAIT_DONE, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_hold: got state %0d expected %0d", oDBG_STATE, ST_WAIT_DONE); end
    sent_q.delete();
    for (int i = 0; i < 9; i++) begin
      iWRen = 1'b1;
      iData = 8'h10 + 8'(i);
      checks++; if (oFULL !== (i == 8)) begin failures++; $display("FAIL b2b_full_%0d: got %0b expected %0b", i, oFULL, (i == 8)); end
      checks++; if (oDROP !== 1'b0) begin failures++; $display("FAIL b2b_nodrop_%0d: got %0b expected 0", i, oDROP); end
      if (i < 8) exp_q.push_back(8'h10 + 8'(i));
      tick();
    end
    iWRen = 1'b0;
    checks++; if (oDROP !== 1'b1) begin failures++; $display("FAIL b2b_drop: got %0b expected 1", oDROP); end
    tick();
    checks++; if (oDROP !== 1'b0) begin failures++; $display("FAIL b2b_drop_pulse: got %0b expected 0", oDROP); end
    force_busy = 1'b0;
    model_en   = 1'b1;
    busy_len   = 3;
    n = 0;
    while (sent_q.size() < 8 && n < 500) begin
      tick();
      n++;
    end
    wait_state(ST_IDLE, 40, ok);
    repeat (20) tick();
    checks++; if (sent_q.size() !== 8) begin failures++; $display("FAIL b2b_count: got %0d expected 8", sent_q.size()); end
    while (exp_q.size() > 0 && sent_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = sent_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_order: got %0h expected %0h", g, e); end
    end
    exp_q.delete();
    checks++; if (oEMPTY !== 1'b1) begin failures++; $display("FAIL b2b_empty: got %0b expected 1", oEMPTY); end
  endtask

  task automatic test_clean_finish();
    bit ok;
    int n;
    model_en   = 1'b0;
    force_busy = 1'b1;
    write_byte(8'hB0);
    wait_state(ST_WAIT_DONE, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cf_hold: got state %0d expected %0d", oDBG_STATE, ST_WAIT_DONE); end
    sent_q.delete();
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    checks++; if (oEMPTY !== 1'b0) begin failures++; $display("FAIL cf_queued: got %0b expected 0", oEMPTY); end
    iCLEAN  = 1'b1;
    iFINISH = 1'b1;
    iWRen   = 1'b1;
    iData   = 8'h99;
    tick();
    iWRen = 1'b0;
    checks++; if (oEMPTY !== 1'b1) begin failures++; $display("FAIL cf_flushed: got %0b expected 1", oEMPTY); end
    checks++; if (oDROP !== 1'b0) begin failures++; $display("FAIL cf_nodrop: got %0b expected 0", oDROP); end
    force_busy = 1'b0;
    model_en   = 1'b1;
    busy_len   = 3;
    n = 0;
    while (sent_q.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    wait_state(ST_IDLE, 40, ok);
    repeat (20) tick();
    checks++; if (sent_q.size() !== 2) begin failures++; $display("FAIL cf_count: got %0d expected 2", sent_q.size()); end
    exp_q.push_back(ACK_CLEAN);
    exp_q.push_back(ACK_FINISH);
    while (exp_q.size() > 0 && sent_q.size() > 0) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = sent_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL cf_order: got %0h expected %0h", g, e); end
    end
    exp_q.delete();
    iCLEAN  = 1'b0;
    iFINISH = 1'b0;
    tick();
  endtask

  task automatic test_baud();
    bit ok;
    model_en = 1'b1;
    busy_len = 10;
    irate_control = 2'b00;
    tick();
    write_byte(8'h55);
    wait_state(ST_WAIT_DONE, 20, ok);
    irate_control = 2'b10;
    tick();
    checks++; if (oBAUD_SEL !== 2'b00) begin failures++; $display("FAIL baud_midbyte: got %0b expected 00", oBAUD_SEL); end
    wait_state(ST_IDLE, 40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL baud_idle: got state %0d expected %0d", oDBG_STATE, ST_IDLE); end
    checks++; if (oBAUD_SEL !== 2'b00) begin failures++; $display("FAIL baud_first_idle: got %0b expected 00", oBAUD_SEL); end
    tick();
    checks++; if (oBAUD_SEL !== 2'b10) begin failures++; $display("FAIL baud_load: got %0b expected 10", oBAUD_SEL); end
    irate_control = 2'b11;
    tick();
    tick();
    checks++; if (oBAUD_SEL !== 2'b10) begin failures++; $display("FAIL baud_hold11: got %0b expected 10", oBAUD_SEL); end
    irate_control = 2'b01;
    tick();
    checks++; if (oBAUD_SEL !== 2'b01) begin failures++; $display("FAIL baud_01: got %0b expected 01", oBAUD_SEL); end
    irate_control = 2'b00;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    model_en   = 1'b0;
    force_busy = 1'b0;
    write_byte(8'h77);
    tick();
    checks++; if (oTX_START !== 1'b1) begin failures++; $display("FAIL to_first_start: got %0b expected 1", oTX_START); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!oTX_START && n < 40);
      checks++; if (n !== BT + 1) begin failures++; $display("FAIL to_period_%0d: got %0d expected %0d", k, n, BT + 1); end
      checks++; if (oTX_DATA !== 8'h77) begin failures++; $display("FAIL to_data_%0d: got %0h expected 77", k, oTX_DATA); end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sz;
    model_en = 1'b1;
    busy_len = 10;
    write_byte(8'h66);
    wait_state(ST_WAIT_DONE, 20, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rm_wait_done: got state %0d expected %0d", oDBG_STATE, ST_WAIT_DONE); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (oDBG_STATE !== ST_IDLE) begin failures++; $display("FAIL rm_state: got %0d expected %0d", oDBG_STATE, ST_IDLE); end
    checks++; if (oTX_DATA !== 8'h00) begin failures++; $display("FAIL rm_data: got %0h expected 00", oTX_DATA); end
    checks++; if (oTX_START !== 1'b0) begin failures++; $display("FAIL rm_start: got %0b expected 0", oTX_START); end
    checks++; if (oEMPTY !== 1'b1 || oFULL !== 1'b0 || oDROP !== 1'b0) begin failures++; $display("FAIL rm_flags: got empty=%0b full=%0b drop=%0b expected 1 0 0", oEMPTY, oFULL, oDROP); end
    sz = sent_q.size();
    repeat (40) tick();
    checks++; if (sent_q.size() !== sz) begin failures++; $display("FAIL rm_no_start: got %0d starts expected 0", sent_q.size() - sz); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    iWRen         = 1'b0;
    iData         = 8'h00;
    irate_control = 2'b00;
    iCLEAN        = 1'b0;
    iFINISH       = 1'b0;
    force_busy    = 1'b0;
    model_en      = 1'b0;
    busy_len      = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_clean_finish();
    test_baud();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the data FIFO depth in bytes (power of 2).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16, meaning the cycles to wait for transmitter busy before restarting the byte.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port iWRen, input, 1 bit: write strobe; each high cycle writes one byte.
REQ-006 SHALL have port iData, input, 8 bits: write data, qualified by iWRen.
REQ-007 SHALL have port irate_control, input, 2 bits: requested baud select (00, 01, 10).
REQ-008 SHALL have port iCLEAN, input, 1 bit: level clean request.
REQ-009 SHALL have port iFINISH, input, 1 bit: level control-finish request.
REQ-010 SHALL have port iTX_BUSY, input, 1 bit: the UART transmitter is shifting a byte.
REQ-011 SHALL have port oTX_START, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-012 SHALL have port oTX_DATA, output, 8 bits: the byte being sent.
REQ-013 SHALL have port oBAUD_SEL, output, 2 bits: the baud select currently applied to the transmitter.
REQ-014 SHALL have port oFULL, output, 1 bit: the FIFO holds DEPTH bytes.
REQ-015 SHALL have port oEMPTY, output, 1 bit: the FIFO holds 0 bytes.
REQ-016 SHALL have port oDROP, output, 1 bit: one-cycle pulse when a write is discarded.

Function
REQ-017 SHALL detect rising edges of iCLEAN and iFINISH against a registered copy of each; only edges act.
REQ-018 On an iCLEAN edge, SHALL empty the FIFO in that cycle, set clean_pend, and discard any same-cycle write without pulsing oDROP.
REQ-019 On an iFINISH edge, SHALL set finish_pend.
REQ-020 A write while oFULL=1 SHALL be discarded with oDROP=1 in the following cycle; a simultaneous pop SHALL NOT free space for that write.
REQ-021 FSM states SHALL be IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-022 IDLE SHALL select a source by fixed priority: clean_pend (byte 0x43 'C'), then finish_pend (byte 0x4B 'K'), then FIFO head; it SHALL latch the byte into oTX_DATA, clear the flag or pop the FIFO, and go to START.
REQ-023 START SHALL last exactly one cycle with oTX_START=1, then go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL go to WAIT_DONE when iTX_BUSY=1; after BUSY_TIMEOUT cycles without busy it SHALL return to START and resend the same byte.
REQ-025 WAIT_DONE SHALL go to IDLE when iTX_BUSY=0.
REQ-026 oTX_DATA SHALL be stable from START through WAIT_DONE.
REQ-027 Latency: a write in cycle N to an empty FIFO with the FSM in IDLE SHALL produce oTX_START in cycle N+2.
REQ-028 oBAUD_SEL SHALL load irate_control only while in IDLE and no source is pending; value 11 SHALL be ignored (hold previous).
REQ-029 oFULL and oEMPTY SHALL be registered and reflect occupancy after each cycle's push, pop and flush.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be a (log2(DEPTH)+1)-bit count.

Reset
REQ-031 When reset=1 at a clock edge: FSM to IDLE, FIFO empty, clean_pend/finish_pend/edge registers 0, oTX_START 0, oTX_DATA 0x00, oBAUD_SEL 00, oFULL 0, oEMPTY 1, oDROP 0.
REQ-032 Reset mid-transmission SHALL abandon the byte; no oTX_START may follow until a new source exists.

Structure
REQ-033 Package tx_sched_pkg SHALL hold the state encoding, ACK_CLEAN=0x43, ACK_FINISH=0x4B, and the baud-select codes.
REQ-034 The FIFO SHALL be a sub-module sync_fifo (DEPTH x 8, synchronous push/pop/flush, full/empty flags).

Verification
REQ-035 Write 0x41 in IDLE with iTX_BUSY modeled 10 cycles -> oTX_START two cycles later, oTX_DATA=0x41, return to IDLE after busy falls.
REQ-036 Write 9 bytes back-to-back with iTX_BUSY held 1 -> oFULL after 8 bytes, oDROP pulse for the 9th, 8 bytes sent in order.
REQ-037 Raise iFINISH and iCLEAN in the same cycle with 3 bytes queued -> FIFO flushed, 0x43 sent then 0x4B, no data bytes.
REQ-038 Change irate_control 00->10 mid-byte -> oBAUD_SEL stays 00 until WAIT_DONE->IDLE with nothing pending, then 10; value 11 holds.
REQ-039 iTX_BUSY never rises -> oTX_START re-pulses every BUSY_TIMEOUT+1 cycles with the same oTX_DATA.
REQ-040 Assert reset during WAIT_DONE -> all outputs at reset values next cycle, and no further oTX_START occurs.
